// File: rtl/uart_tx_serializer_if.sv
// Handshake and line bundle between a TX data source and the UART serializer.
// The source side uses the master modport; the serializer uses slave.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  send;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            parity_type;
    logic                  data_out;
    logic                  parity_out;
    logic                  tx_active;
    logic                  tx_done;

    modport master (
        output send, data, parity_type,
        input  data_out, parity_out, tx_active, tx_done
    );

    modport slave (
        input  send, data, parity_type,
        output data_out, parity_out, tx_active, tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Parametrised UART transmit serializer: start, DATA_WIDTH data bits LSB first, optional parity, stop bits.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for send (or break_req)
// ST_START  | start bit, line low
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when parity enabled for this frame)
// ST_STOP   | stop bit(s), line high
// ST_BREAK  | line held low for a frame-length break (break build only)
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef UART_TX_BREAK_EN
    input  logic break_req,
`endif
    uart_tx_serializer_if.slave tx_if
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [3:0]    BREAK_LAST = 4'(DATA_WIDTH + STOP_BITS);

    logic [2:0]            state;
    logic [BW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en;
    logic                  data_out_q;
    logic                  parity_out_q;
    logic                  tx_active_q;
    logic                  tx_done_q;
    logic                  baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    assign tx_if.data_out   = data_out_q;
    assign tx_if.parity_out = parity_out_q;
    assign tx_if.tx_active  = tx_active_q;
    assign tx_if.tx_done    = tx_done_q;

`ifdef UART_TX_BREAK_EN
    logic [3:0] break_last;
    assign break_last = par_en ? (BREAK_LAST + 4'd1) : BREAK_LAST;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_en       <= 1'b0;
            data_out_q   <= 1'b1;
            parity_out_q <= 1'b0;
            tx_active_q  <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (state != ST_IDLE)
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state       <= ST_BREAK;
                        data_out_q  <= 1'b0;
                        tx_active_q <= 1'b1;
                        par_en      <= ^tx_if.parity_type;
                    end else
`endif
                    if (tx_if.send) begin
                        state       <= ST_START;
                        data_out_q  <= 1'b0;
                        tx_active_q <= 1'b1;
                        shift_reg   <= tx_if.data;
                        // 01 and 10 are the only parity-enabled codes
                        par_en      <= ^tx_if.parity_type;
                        case (tx_if.parity_type)
                            2'b01:   parity_out_q <= ~^tx_if.data;
                            2'b10:   parity_out_q <= ^tx_if.data;
                            default: parity_out_q <= 1'b0;
                        endcase
                    end
                end

                ST_START: begin
                    if (baud_wrap) begin
                        state      <= ST_DATA;
                        bit_cnt    <= '0;
                        data_out_q <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                    end
                end

                ST_DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (par_en) begin
                                state      <= ST_PARITY;
                                data_out_q <= parity_out_q;
                            end else begin
                                state      <= ST_STOP;
                                data_out_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            data_out_q <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (baud_wrap) begin
                        state      <= ST_STOP;
                        bit_cnt    <= '0;
                        data_out_q <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (baud_wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            state       <= ST_IDLE;
                            bit_cnt     <= '0;
                            data_out_q  <= 1'b1;
                            tx_active_q <= 1'b0;
                            tx_done_q   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (baud_wrap) begin
                        if (bit_cnt >= break_last && !break_req) begin
                            // a break is followed by exactly one stop bit
                            state      <= ST_STOP;
                            bit_cnt    <= STOP_LAST;
                            data_out_q <= 1'b1;
                        end else if (bit_cnt < break_last) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
`endif

                default: begin
                    state       <= ST_IDLE;
                    bit_cnt     <= '0;
                    data_out_q  <= 1'b1;
                    tx_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
